// File: rtl/mac_seq_ctrl_if.sv
// Operand-in and partial-sum-out valid/ready streams of the MAC sequencer.
// The master modport is the producer/consumer side, the slave modport is the controller side.
`timescale 1ns/1ps
interface mac_seq_ctrl_if #(
  parameter int DATA_BITWIDTH = 8,
  parameter int PROD_BITWIDTH = 2*DATA_BITWIDTH
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_BITWIDTH-1:0] in_iact;
  logic [DATA_BITWIDTH-1:0] in_wght;
  logic                     out_valid;
  logic                     out_ready;
  logic [PROD_BITWIDTH-1:0] out_psum;

  modport master (
    output in_valid, in_iact, in_wght, out_ready,
    input  in_ready, out_valid, out_psum
  );

  modport slave (
    input  in_valid, in_iact, in_wght, out_ready,
    output in_ready, out_valid, out_psum
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// MAC sequencer: clears the accumulator, feeds one window of operand pairs, drains, presents the sum.
// Optional macro MAC_SEQ_CTRL_PERF_EN adds perf_stall_cnt (FEED cycles with in_valid low).
`timescale 1ns/1ps
module mac_seq_ctrl #(
  parameter int DATA_BITWIDTH = 8,
  parameter int PROD_BITWIDTH = 2*DATA_BITWIDTH,
  parameter int KERNEL_SIZE   = 9,
  parameter int LEN_BITWIDTH  = 8,
  parameter int MAC_LAT       = 1
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     enable,
  input  logic [LEN_BITWIDTH-1:0]  cfg_len,
  mac_seq_ctrl_if.slave            io,
  output logic [DATA_BITWIDTH-1:0] mac_iact,
  output logic [DATA_BITWIDTH-1:0] mac_wght,
  output logic                     mac_clr,
  input  logic [PROD_BITWIDTH-1:0] mac_dout,
  output logic                     busy
`ifdef MAC_SEQ_CTRL_PERF_EN
  ,
  output logic [LEN_BITWIDTH-1:0]  perf_stall_cnt
`endif
);

  localparam int DRAIN_BITWIDTH = (MAC_LAT < 1) ? 1 : $clog2(MAC_LAT + 2);
  localparam logic [DRAIN_BITWIDTH-1:0] DRAIN_LAST = DRAIN_BITWIDTH'(MAC_LAT);
  localparam logic [DRAIN_BITWIDTH-1:0] DRAIN_ONE  = DRAIN_BITWIDTH'(1);
  localparam logic [LEN_BITWIDTH-1:0]   KERNEL_LEN = LEN_BITWIDTH'(KERNEL_SIZE);
  localparam logic [LEN_BITWIDTH-1:0]   LEN_ONE    = LEN_BITWIDTH'(1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } state_e;

  state_e                     state_q, state_d;
  logic [LEN_BITWIDTH-1:0]    len_q, len_d;
  logic [LEN_BITWIDTH-1:0]    cnt_q, cnt_d;
  logic [DRAIN_BITWIDTH-1:0]  drain_q, drain_d;
  logic [DATA_BITWIDTH-1:0]   iact_q, iact_d;
  logic [DATA_BITWIDTH-1:0]   wght_q, wght_d;
  logic                       clr_q, clr_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [PROD_BITWIDTH-1:0]   psum_q, psum_d;
  logic                       busy_q, busy_d;
  logic                       accept_s;

  // in_ready_q is high exactly while in FEED, so this is the FEED accept strobe
  assign accept_s = io.in_valid && in_ready_q;

  // Next-state and datapath computation; operands default to zero so idle edges add 0*0
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    iact_d  = '0;
    wght_d  = '0;
    psum_d  = psum_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        len_d   = (cfg_len == '0) ? KERNEL_LEN : cfg_len;
        cnt_d   = '0;
        drain_d = '0;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        if (accept_s) begin
          iact_d = io.in_iact;
          wght_d = io.in_wght;
          cnt_d  = cnt_q + LEN_ONE;
          if (cnt_q == (len_q - LEN_ONE)) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_FEED;
          end
        end else begin
          state_d = ST_FEED;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          psum_d  = mac_dout;
          drain_d = '0;
          state_d = ST_OUT;
        end else begin
          drain_d = drain_q + DRAIN_ONE;
          state_d = ST_DRAIN;
        end
      end
      ST_OUT: begin
        if (out_valid_q && io.out_ready) begin
          state_d = enable ? ST_CLEAR : ST_IDLE;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    clr_d       = (state_d == ST_CLEAR);
    in_ready_d  = (state_d == ST_FEED);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      drain_q     <= '0;
      iact_q      <= '0;
      wght_q      <= '0;
      clr_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      psum_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      iact_q      <= iact_d;
      wght_q      <= wght_d;
      clr_q       <= clr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      psum_q      <= psum_d;
      busy_q      <= busy_d;
    end
  end

  assign mac_iact     = iact_q;
  assign mac_wght     = wght_q;
  assign mac_clr      = clr_q;
  assign io.in_ready  = in_ready_q;
  assign io.out_valid = out_valid_q;
  assign io.out_psum  = psum_q;
  assign busy         = busy_q;

`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [LEN_BITWIDTH-1:0] stall_q, stall_d;

  // Saturating count of FEED cycles starved of input; frozen outside FEED
  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_CLEAR) begin
      stall_d = '0;
    end else if ((state_q == ST_FEED) && !io.in_valid && (stall_q != '1)) begin
      stall_d = stall_q + LEN_ONE;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed windows plus randomized windows against a sum-of-products model.
`timescale 1ns/1ps
module tb_mac_seq_ctrl;
  localparam int DW = 8;
  localparam int PW = 16;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rstN;
  logic          enable;
  logic [LW-1:0] cfg_len;
  logic [DW-1:0] mac_iact;
  logic [DW-1:0] mac_wght;
  logic          mac_clr;
  logic [PW-1:0] mac_dout;
  logic          busy;
`ifdef MAC_SEQ_CTRL_PERF_EN
  logic [LW-1:0] perf_stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int pa [0:255];
  int pb [0:255];

  mac_seq_ctrl_if #(.DATA_BITWIDTH(DW), .PROD_BITWIDTH(PW)) bus ();

  mac_seq_ctrl #(
    .DATA_BITWIDTH(DW), .PROD_BITWIDTH(PW), .KERNEL_SIZE(9), .LEN_BITWIDTH(LW), .MAC_LAT(1)
  ) dut (
    .clk      (clk),
    .rstN     (rstN),
    .enable   (enable),
    .cfg_len  (cfg_len),
    .io       (bus.slave),
    .mac_iact (mac_iact),
    .mac_wght (mac_wght),
    .mac_clr  (mac_clr),
    .mac_dout (mac_dout),
    .busy     (busy)
`ifdef MAC_SEQ_CTRL_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Single-cycle unsigned MAC with synchronous clear
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      mac_dout <= '0;
    end else if (mac_clr) begin
      mac_dout <= '0;
    end else begin
      mac_dout <= mac_dout + ({8'd0, mac_iact} * {8'd0, mac_wght});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_psum(input int n);
    longint unsigned s;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
    return 32'(s % (64'd1 << PW));
  endfunction

  task automatic load_w1();
    for (int i = 0; i < 9; i++) begin pa[i] = i + 1; pb[i] = 9 - i; end
  endtask

  // Runs one window from IDLE or CLEAR; bubbles of bub_len cycles before pair bub_pos, bp cycles of backpressure
  task automatic run_window(input int cfg, input int bub_pos, input int bub_len, input int bp,
                            input bit drop, input bit next_en, input string nm);
    int len, k, guard, stalls;
    bit acc;
    logic [31:0] exp;
    len = (cfg == 0) ? 9 : cfg;
    exp = ref_psum(len);
    cfg_len = LW'(cfg);
    enable = 1'b1;
    k = 0; guard = 0; stalls = 0;
    while (k < len && guard < 2000) begin
      if (bus.in_ready && k == bub_pos && stalls < bub_len) begin
        bus.in_valid = 1'b0;
        stalls++;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_iact  = DW'(pa[k]);
        bus.in_wght  = DW'(pb[k]);
      end
      acc = bus.in_valid && bus.in_ready;
      if (drop && k == len / 2) enable = 1'b0;
      if (k == 1) cfg_len = LW'($urandom);
      @(negedge clk);
      guard++;
      if (acc) k++;
    end
    bus.in_valid = 1'b0;
    chk({nm, "_feed_done"}, 32'(k == len), 32'd1);
    chk({nm, "_drain1_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_drain1_ready"}, 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk({nm, "_drain2_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_psum"}, 32'(bus.out_psum), exp);
    chk({nm, "_out_ready0"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_out_busy"}, 32'(busy), 32'd1);
`ifdef MAC_SEQ_CTRL_PERF_EN
    chk({nm, "_stalls"}, 32'(perf_stall_cnt), 32'((stalls > 255) ? 255 : stalls));
`endif
    bus.out_ready = 1'b0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk({nm, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_bp_psum"}, 32'(bus.out_psum), exp);
      chk({nm, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    enable = drop ? 1'b0 : next_en;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({nm, "_hs_valid"}, 32'(bus.out_valid), 32'd0);
    if (!enable) begin
      chk({nm, "_idle_busy"}, 32'(busy), 32'd0);
      chk({nm, "_idle_ready"}, 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      chk({nm, "_idle_hold"}, 32'(busy), 32'd0);
    end else begin
      chk({nm, "_next_clr"}, 32'(mac_clr), 32'd1);
      chk({nm, "_next_busy"}, 32'(busy), 32'd1);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_mac_iact"}, 32'(mac_iact), 32'd0);
    chk({nm, "_mac_wght"}, 32'(mac_wght), 32'd0);
    chk({nm, "_mac_clr"}, 32'(mac_clr), 32'd0);
    chk({nm, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_out_psum"}, 32'(bus.out_psum), 32'd0);
    chk({nm, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int k, guard, cfg, len;
    bit acc, nxt;
    rstN = 1'b0; enable = 1'b0; cfg_len = '0;
    bus.in_valid = 1'b0; bus.in_iact = '0; bus.in_wght = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rstN = 1'b1;
    @(negedge clk);
    chk("idle_no_enable", 32'(busy), 32'd0);

    load_w1();
    run_window(0, 99, 0, 0, 1'b0, 1'b1, "w1");
    pa[0]=5; pb[0]=1; pa[1]=4; pb[1]=2; pa[2]=5; pb[2]=3;
    pa[3]=4; pb[3]=1; pa[4]=5; pb[4]=2; pa[5]=4; pb[5]=3;
    pa[6]=5; pb[6]=1; pa[7]=4; pb[7]=2; pa[8]=5; pb[8]=3;
    run_window(0, 99, 0, 0, 1'b0, 1'b0, "w2");
    load_w1();
    run_window(0, 4, 3, 0, 1'b0, 1'b0, "bubble");
    for (int i = 0; i < 4; i++) begin pa[i] = 255; pb[i] = 255; end
    run_window(4, 99, 0, 5, 1'b0, 1'b0, "bp");

    load_w1();
    enable = 1'b1; cfg_len = '0; k = 0; guard = 0;
    while (k < 5 && guard < 100) begin
      bus.in_valid = 1'b1;
      bus.in_iact = DW'(pa[k]);
      bus.in_wght = DW'(pb[k]);
      acc = bus.in_valid && bus.in_ready;
      @(negedge clk);
      guard++;
      if (acc) k++;
    end
    rstN = 1'b0;
    #1;
    chk_all_zero("midrst");
    bus.in_valid = 1'b0; enable = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_no_valid", 32'(bus.out_valid), 32'd0);
    end
    rstN = 1'b1;
    @(negedge clk);
    run_window(0, 99, 0, 0, 1'b0, 1'b0, "post_rst");

    load_w1();
    run_window(0, 99, 0, 1, 1'b1, 1'b1, "endrop");

    nxt = 1'b0;
    for (int r = 0; r < 10; r++) begin
      cfg = $urandom_range(0, 24);
      len = (cfg == 0) ? 9 : cfg;
      for (int i = 0; i < len; i++) begin
        pa[i] = $urandom_range(0, 255);
        pb[i] = $urandom_range(0, 255);
      end
      nxt = 1'($urandom_range(0, 1));
      run_window(cfg, $urandom_range(0, len - 1), $urandom_range(0, 3),
                 $urandom_range(0, 3), 1'b0, nxt, $sformatf("rnd%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
